// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_LEN   = 16;
  localparam int DEF_FIFO_DEPTH = 16;

  // Error class of the most recent request, used for reporting in benches.
  typedef enum logic [1:0] {
    FIFO_OK,
    FIFO_OVF,
    FIFO_UDF
  } fifo_err_e;

  // Width needed to hold an occupancy value in 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH binary pointer: counts 0..DEPTH-1 and wraps, so any depth
// (including non-power-of-two) can be addressed without pointer aliasing.
module fifo_wrap_ptr #(
  parameter int DEPTH   = 16,
  parameter int PTR_LEN = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  output logic [PTR_LEN-1:0] ptr
);

  // Advance on enable, wrapping at DEPTH-1; a flush returns the pointer to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PTR_LEN'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_LEN'(1);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise
// data_out is a registered read valid the cycle after an accepted rd_en.
import fifo_pkg::*;

module sync_fifo_param #(
  parameter int DATA_LEN      = DEF_DATA_LEN,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_LEN       = cnt_width(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                wrt_en,
  output logic                wrt_full,
  output logic                almost_full,
  output logic [DATA_LEN-1:0] data_out,
  input  logic                rd_en,
  output logic                rd_empty,
  output logic                almost_empty,
  output logic [CNT_LEN-1:0]  count,
  output logic                overflow,
  output logic                underflow
);

  localparam int PTR_LEN = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_LEN-1:0]  wr_ptr;
  logic [PTR_LEN-1:0]  rd_ptr;
  logic                rd_acc;
  logic                wr_acc;
  logic                ovf_evt;
  logic                udf_evt;
  logic [CNT_LEN-1:0]  count_next;

  // Accept decisions: empty blocks reads, full blocks writes unless a read
  // frees a slot in the same cycle; a flush swallows every request silently.
  always_comb begin
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!clear) begin
      rd_acc  = rd_en & ~rd_empty;
      wr_acc  = wrt_en & (~wrt_full | rd_acc);
      ovf_evt = wrt_en & ~wr_acc;
      udf_evt = rd_en & ~rd_acc;
    end
  end

  // Next occupancy; every status flag is derived from it so they line up with count.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (wr_acc && !rd_acc) begin
      count_next = count + CNT_LEN'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CNT_LEN'(1);
    end
  end

  fifo_wrap_ptr #(
    .DEPTH   (FIFO_DEPTH),
    .PTR_LEN (PTR_LEN)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (wr_acc),
    .ptr     (wr_ptr)
  );

  fifo_wrap_ptr #(
    .DEPTH   (FIFO_DEPTH),
    .PTR_LEN (PTR_LEN)
  ) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (rd_acc),
    .ptr     (rd_ptr)
  );

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Occupancy and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      wrt_full     <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      wrt_full     <= (int'(count_next) == FIFO_DEPTH);
      almost_full  <= (int'(count_next) >= AFULL_THRESH);
      rd_empty     <= (count_next == '0);
      almost_empty <= (int'(count_next) <= AEMPTY_THRESH);
    end
  end

  // Sticky error flags, only cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end
      if (udf_evt) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only pops it.
  assign data_out = mem[rd_ptr];
`else
  // Registered read: capture the head word on an accepted read, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule
